alu_secuencial: RTL and testbench
=================================

Name: alu_secuencial

Overview:
- Multi-cycle ALU directly downstream of the ALU decoder; consumes its 2-bit ALUOp (00 ADD, 01 XOR, 10 AND, 11 SRA) plus two operands.
- ADD, XOR and AND complete in one clock. SRA uses an iterative 1-bit-per-cycle shifter, so a barrel shifter is not needed.
- Start/busy/done handshake toward the datapath control; result and zero flag are registered and held until the next completion.

Parameters:
- WIDTH, 32, operand/result width in bits.
- SHAMT_W, $clog2(WIDTH) (5), width of the shift-amount field taken from B.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  request; accepted only when state is IDLE.
- ALUOp  in  2  operation code from ALU decoder; sampled at accept only.
- A  in  WIDTH  operand A / value to shift; sampled at accept only.
- B  in  WIDTH  operand B; for SRA only B[SHAMT_W-1:0] is used.
- result  out  WIDTH  registered result; held until next completion.
- zero  out  1  equals (result == 0), derived from the result register.
- busy  out  1  high while an SRA is iterating (state SHIFT).
- done  out  1  one-cycle registered pulse: result and zero are valid and new.

Behaviour:
- Reset (async, any time, including mid-SRA): state=IDLE, result=0, zero=1, busy=0, done=0, cnt=0, acc=0. An in-flight operation is dropped and raises no done.
- States: IDLE, SHIFT.
- Accept: start=1 and state=IDLE at a rising edge (cycle N). A, B and ALUOp are latched at that edge. Later input changes are ignored.
- ADD/XOR/AND: at the accept edge, result <= A+B, A^B or A&B. done=1 in cycle N+1. State stays IDLE.
- ADD wraps modulo 2^WIDTH. No carry or overflow output.
- SRA with k = B[SHAMT_W-1:0]:
  - k=0: result <= A at the accept edge; done in cycle N+1.
  - k>0: acc <= A, cnt <= k, state -> SHIFT.
  - Each edge in SHIFT: acc <= {acc[MSB], acc[WIDTH-1:1]}, cnt <= cnt-1.
  - The edge where cnt==1 also loads result <= shifted value, pulses done and returns state to IDLE.
  - Timing: busy=1 in cycles N+1..N+k; done in cycle N+1+k. Total latency k+1 edges.
- Sign bit is replicated on every shift step. Upper bits of B are ignored for SRA, e.g. B=0x25 shifts by 5.
- start while busy=1: ignored, not queued.
- start during a done cycle: accepted, because state is IDLE. Back-to-back single-cycle ops give done every cycle.
- done is high for exactly one cycle per accepted operation. It never overlaps busy.
- result and zero change only on a done edge or on reset.
- Undefined ALUOp cannot occur: all 4 codes are legal.

Decomposition:
- Shared package alu_pkg:
  - ALUOp localparams ALUOP_ADD=2'b00, ALUOP_XOR=2'b01, ALUOP_AND=2'b10, ALUOP_SRA=2'b11. The ALU decoder uses the same constants.
  - State encoding IDLE/SHIFT.
- One natural sub-module: alu_sra_iter (acc and cnt registers, load/step/last signals). The top level holds the FSM, the single-cycle ops and the result/zero/done registers.

Test Plan:
- ADD: A=0xFFFFFFFF, B=1, start at cycle N -> done=1 at N+1; result=0x00000000, zero=1, busy=0 throughout.
- XOR, then AND back-to-back, start held high:
  - XOR A=0xF0F0F0F0, B=0xFF00FF00 -> result 0x0FF00FF0, done at N+1.
  - AND with same operands -> result 0xF000F000, done at N+2, zero=0.
- SRA: A=0x80000000, B=4 -> busy=1 cycles N+1..N+4; done at N+5; result=0xF8000000.
- SRA shift-amount edges:
  - B=0 -> result=A, done at N+1, busy never high.
  - B=0x25 with A=0x40000000 -> shift 5, result 0x02000000, done at N+6.
- Handshake: during SRA k=3, pulse start with ALUOp=ADD and change A/B at N+2 -> ignored; single done at N+4 with the original SRA result.
- Reset mid-op: assert rst asynchronously (between clock edges) during SRA k=10 at N+3 -> busy, done and result drop to 0 immediately, zero=1; no done afterwards; a new ADD after release works normally.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU operation codes and sequencer state encoding
package alu_pkg;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_XOR = 2'b01;
    localparam logic [1:0] ALUOP_AND = 2'b10;
    localparam logic [1:0] ALUOP_SRA = 2'b11;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } alu_state_t;

endpackage

// File: rtl/alu_sra_iter.sv
// rtl/alu_sra_iter.sv - iterative arithmetic right shifter, one bit per step
module alu_sra_iter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   a,
    input  logic [SHAMT_W-1:0] k,
    output logic [WIDTH-1:0]   shifted,
    output logic               last
);

    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;

    // shifted is the value acc takes on this step, so the top can capture it on the last one
    assign shifted = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
    assign last    = (cnt_q == SHAMT_W'(1));

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (load) begin
            acc_d = a;
            cnt_d = k;
        end else if (step) begin
            acc_d = shifted;
            cnt_d = cnt_q - SHAMT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/alu_secuencial.sv
// rtl/alu_secuencial.sv - multi-cycle ALU with start/busy/done handshake
module alu_secuencial
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       ALUOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    alu_state_t       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             done_q, done_d;

    logic             sra_load, sra_step, sra_last;
    logic [WIDTH-1:0] sra_shifted;
    logic [SHAMT_W-1:0] shamt;

    assign shamt = B[SHAMT_W-1:0];

    alu_sra_iter #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_sra (
        .clk     (clk),
        .rst     (rst),
        .load    (sra_load),
        .step    (sra_step),
        .a       (A),
        .k       (shamt),
        .shifted (sra_shifted),
        .last    (sra_last)
    );

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        done_d   = 1'b0;
        sra_load = 1'b0;
        sra_step = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    case (ALUOp)
                        ALUOP_ADD: begin
                            result_d = A + B;
                            done_d   = 1'b1;
                        end
                        ALUOP_XOR: begin
                            result_d = A ^ B;
                            done_d   = 1'b1;
                        end
                        ALUOP_AND: begin
                            result_d = A & B;
                            done_d   = 1'b1;
                        end
                        default: begin
                            // a zero shift finishes like the single-cycle ops
                            if (shamt == '0) begin
                                result_d = A;
                                done_d   = 1'b1;
                            end else begin
                                sra_load = 1'b1;
                                state_d  = SHIFT;
                            end
                        end
                    endcase
                end
            end
            SHIFT: begin
                sra_step = 1'b1;
                if (sra_last) begin
                    result_d = sra_shifted;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign result = result_q;
    assign zero   = (result_q == '0);
    assign busy   = (state_q == SHIFT);
    assign done   = done_q;

endmodule

// File: tb/tb_alu_secuencial.sv
// tb/tb_alu_secuencial.sv - directed self-checking bench for alu_secuencial
module tb_alu_secuencial;
    import alu_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  ALUOp;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] result;
    logic        zero;
    logic        busy;
    logic        done;

    int checks;
    int failures;

    alu_secuencial #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .ALUOp  (ALUOp),
        .A      (A),
        .B      (B),
        .result (result),
        .zero   (zero),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if (result !== 32'h0 || zero !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: result=%h zero=%b busy=%b done=%b, want 0/1/0/0",
                     result, zero, busy, done);
        end
        step();
        rst = 1'b0;
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: done=%b busy=%b, want 0/0", done, busy);
        end
    endtask

    task automatic test_add();
        ALUOp = ALUOP_ADD; A = 32'hFFFF_FFFF; B = 32'h1; start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || result !== 32'h0 || zero !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL add_wrap: done=%b result=%h zero=%b busy=%b, want 1/00000000/1/0",
                     done, result, zero, busy);
        end
        step();
        checks++;
        if (done !== 1'b0 || result !== 32'h0) begin
            failures++;
            $display("FAIL add_done_pulse: done=%b result=%h, want 0/00000000", done, result);
        end
    endtask

    task automatic test_back_to_back();
        ALUOp = ALUOP_XOR; A = 32'hF0F0_F0F0; B = 32'hFF00_FF00; start = 1'b1;
        step();
        checks++;
        if (done !== 1'b1 || result !== 32'h0FF0_0FF0) begin
            failures++;
            $display("FAIL xor: done=%b result=%h, want 1/0ff00ff0", done, result);
        end
        ALUOp = ALUOP_AND;
        step();
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || result !== 32'hF000_F000 || zero !== 1'b0) begin
            failures++;
            $display("FAIL and_b2b: done=%b result=%h zero=%b, want 1/f000f000/0",
                     done, result, zero);
        end
        step();
        checks++;
        if (done !== 1'b0 || result !== 32'hF000_F000) begin
            failures++;
            $display("FAIL b2b_hold: done=%b result=%h, want 0/f000f000", done, result);
        end
    endtask

    task automatic test_sra();
        int bad;
        ALUOp = ALUOP_SRA; A = 32'h8000_0000; B = 32'd4; start = 1'b1;
        step();
        start = 1'b0;
        bad = 0;
        for (int i = 1; i <= 4; i++) begin
            if (busy !== 1'b1 || done !== 1'b0) bad++;
            if (i < 4) step();
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL sra4_busy: %0d bad cycles of busy=1/done=0 window, want 0", bad);
        end
        step();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || result !== 32'hF800_0000) begin
            failures++;
            $display("FAIL sra4_result: done=%b busy=%b result=%h, want 1/0/f8000000",
                     done, busy, result);
        end
        step();
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL sra4_done_pulse: done=%b, want 0", done);
        end
    endtask

    task automatic test_sra_edges();
        int bad;
        ALUOp = ALUOP_SRA; A = 32'h8765_4321; B = 32'h0; start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || result !== 32'h8765_4321) begin
            failures++;
            $display("FAIL sra0: done=%b busy=%b result=%h, want 1/0/87654321",
                     done, busy, result);
        end
        step();
        ALUOp = ALUOP_SRA; A = 32'h4000_0000; B = 32'h25; start = 1'b1;
        step();
        start = 1'b0;
        bad = 0;
        for (int i = 1; i <= 5; i++) begin
            if (busy !== 1'b1 || done !== 1'b0) bad++;
            step();
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL sra_b25_busy: %0d bad cycles, want 0", bad);
        end
        checks++;
        if (done !== 1'b1 || result !== 32'h0200_0000 || busy !== 1'b0) begin
            failures++;
            $display("FAIL sra_b25: done=%b busy=%b result=%h, want 1/0/02000000",
                     done, busy, result);
        end
        step();
    endtask

    task automatic test_start_while_busy();
        int dones;
        ALUOp = ALUOP_SRA; A = 32'h8000_0010; B = 32'd3; start = 1'b1;
        step();
        start = 1'b0;
        step();
        start = 1'b1; ALUOp = ALUOP_ADD; A = 32'h1; B = 32'h1;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_n2: busy=%b, want 1", busy);
        end
        step();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL busy_n3: busy=%b done=%b, want 1/0", busy, done);
        end
        step();
        checks++;
        if (done !== 1'b1 || result !== 32'hF000_0002 || busy !== 1'b0) begin
            failures++;
            $display("FAIL sra_ignore_start: done=%b busy=%b result=%h, want 1/0/f0000002",
                     done, busy, result);
        end
        dones = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (done === 1'b1) dones++;
        end
        checks++;
        if (dones != 0 || result !== 32'hF000_0002) begin
            failures++;
            $display("FAIL single_done: extra dones=%0d result=%h, want 0/f0000002",
                     dones, result);
        end
    endtask

    task automatic test_reset_mid_op();
        int dones;
        ALUOp = ALUOP_SRA; A = 32'h8000_0000; B = 32'd10; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0 || zero !== 1'b1) begin
            failures++;
            $display("FAIL async_reset: busy=%b done=%b result=%h zero=%b, want 0/0/0/1",
                     busy, done, result, zero);
        end
        #1;
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done === 1'b1 || busy === 1'b1) dones++;
        end
        checks++;
        if (dones != 0) begin
            failures++;
            $display("FAIL dropped_op: %0d cycles with done/busy after reset, want 0", dones);
        end
        ALUOp = ALUOP_ADD; A = 32'd5; B = 32'd7; start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || result !== 32'd12 || zero !== 1'b0) begin
            failures++;
            $display("FAIL add_after_reset: done=%b result=%h zero=%b, want 1/0000000c/0",
                     done, result, zero);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst   = 1'b1;
        start = 1'b0;
        ALUOp = ALUOP_ADD;
        A     = '0;
        B     = '0;
        #2;
        test_reset();
        test_add();
        test_back_to_back();
        test_sra();
        test_sra_edges();
        test_start_while_busy();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
